quadc_snap_capture: RTL and testbench
=====================================

Name: quadc_snap_capture

Overview:
Snapshot capture stage directly downstream of the quad-ADC interface. Runs in the adc0_clk domain and consumes the four 8-bit sample streams plus valid/sync. On a software arm and a selectable trigger, packs one sample from each ADC into a 32-bit word and writes a programmable-length burst into an external single-port BRAM. Software reads the BRAM through its own port after done is raised.

Parameters:
ADDR_W, 10, BRAM address width; depth = 2^ADDR_W words.

Ports:
adc0_clk  in  1  capture clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
adc0_data  in  8  ADC0 sample, two's complement
adc1_data  in  8  ADC1 sample
adc2_data  in  8  ADC2 sample
adc3_data  in  8  ADC3 sample
valid  in  1  samples valid this cycle
sync  in  1  sync level from the ADC interface, qualified by valid
ext_trig  in  1  external trigger level
arm  in  1  single-cycle arm request
trig_mode  in  2  0=immediate, 1=sync rising edge, 2=ext_trig high, 3=same as 1
capture_len  in  ADDR_W+1  words to capture; 0 or >2^ADDR_W means 2^ADDR_W
bram_addr  out  ADDR_W  write address
bram_data  out  32  {adc0_data, adc1_data, adc2_data, adc3_data}, adc0 in [31:24]
bram_we  out  1  write enable
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in DONE
words_written  out  ADDR_W+1  words written in the current/last capture

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE. bram_addr=0, bram_data=0, bram_we=0, busy=0, done=0, words_written=0, sync_prev=0. Reset wins over all other inputs, including mid-capture; a partial capture is abandoned and done stays 0.
- sync_prev: updates to sync only on cycles with valid=1.
- sync_edge = valid & sync & ~sync_prev.
- States are IDLE, ARMED, CAPTURE, DONE.
- IDLE/DONE, arm=1 -> ARMED:
  - latch trig_mode and the effective length L (1..2^ADDR_W);
  - clear done and words_written.
- arm while in ARMED or CAPTURE is ignored.
- ARMED: the trigger condition is evaluated on the current input sample.
  - mode 0: valid.
  - mode 1/3: sync_edge.
  - mode 2: valid & ext_trig.
  - The earliest trigger is the first valid cycle after the cycle that carried arm; the arm cycle itself never triggers.
  - On trigger, the trigger sample is word 0. If L=1, go -> DONE; otherwise -> CAPTURE.
- CAPTURE: every cycle with valid=1 writes the next word at consecutive addresses. Cycles with valid=0 write nothing and hold the address.
- After L words have been accepted, go -> DONE. No address wrap occurs, because L<=2^ADDR_W.
- Output pipeline: one register stage. A sample accepted at edge t appears as bram_we=1, bram_addr=n, bram_data=packed word during the cycle after t. bram_we is 0 in every other cycle.
- words_written increments together with each bram_we. It holds its value in DONE until the next arm.
- busy deasserts and done asserts in the same cycle that the last bram_we is presented.
- DONE holds until arm or reset.
- Simultaneous events:
  - arm and trigger in the same cycle while in IDLE: arm only; no write.
  - ext_trig or sync while in IDLE, CAPTURE or DONE: no effect on state. sync_prev still tracks.
- Arithmetic is unsigned. Sample bits are passed through unchanged; there is no sign extension.

Test Plan:
- Reset and idle: hold reset_n=0 for 3 cycles, then toggle valid/sync with no arm -> bram_we never asserts; busy=0, done=0, words_written=0.
- Immediate mode:
  - Stimulus: trig_mode=0, capture_len=4, arm, then valid=1 with adc0..3 = (0x10+k, 0x20+k, 0x30+k, 0x40+k) for k=0..5.
  - Required: 4 writes, addr 0..3, data 0x10203040, 0x11213141, 0x12223242, 0x13233343.
  - Required: done=1 on the 4th write; words_written=4.
- Sync mode with valid gaps:
  - Stimulus: trig_mode=1, capture_len=3, arm; sync held high from arm; 0 -> 1 transition at sample k=5; valid=0 on every third cycle.
  - Required: no trigger while sync stays high from arm. Word 0 = sample 5; addr increments only on valid cycles; 3 writes total.
- Full-depth and length zero: ADDR_W=4, capture_len=0, then 17 (each with trig_mode=0) -> exactly 16 writes, addr 0..15 with no wrap; words_written=16 in both cases.
- Ext trigger plus re-arm:
  - Stimulus: trig_mode=2, capture_len=2, ext_trig pulsed during a valid=0 cycle, then again during a valid=1 cycle.
  - Required: the first pulse is ignored; capture starts on the second.
  - Stimulus: arm mid-CAPTURE, then arm after done.
  - Required: arm mid-CAPTURE is ignored; arm after done clears done and restarts at addr 0.
- Reset mid-capture: capture_len=8, reset_n=0 after 3 writes -> next cycle bram_we=0, state IDLE, done=0, words_written=0.

Source files
------------

// File: rtl/quadc_snap_capture.sv
// Snapshot capture for the quad-ADC front end: on arm + trigger, packs one sample
// per ADC into a 32-bit word and streams a programmable-length burst into a BRAM.
module quadc_snap_capture #(
    parameter int ADDR_W = 10
) (
    input  logic              adc0_clk,
    input  logic              reset_n,
    input  logic [7:0]        adc0_data,
    input  logic [7:0]        adc1_data,
    input  logic [7:0]        adc2_data,
    input  logic [7:0]        adc3_data,
    input  logic              valid,
    input  logic              sync,
    input  logic              ext_trig,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [ADDR_W:0]   capture_len,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_data,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int NUM_LANES = 4;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_req_t;

    state_t state, state_nxt;

    // Lane 3 (adc0) lands in the top byte of the packed word.
    logic [NUM_LANES-1:0][7:0] lane_smp;
    assign lane_smp = {adc0_data, adc1_data, adc2_data, adc3_data};

    logic            sync_prev, sync_edge, trig_hit;
    logic            accept, arm_take, last_word;
    logic [1:0]      mode_q;
    logic [ADDR_W:0] len_q, len_eff, cnt;
    wr_req_t         wr_req;

    assign sync_edge = valid & sync & ~sync_prev;
    assign len_eff   = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;
    assign last_word = (cnt + (ADDR_W+1)'(1)) == len_q;
    assign wr_req    = '{addr: cnt[ADDR_W-1:0], data: lane_smp};

    always_comb begin
        case (mode_q)
            2'd0:    trig_hit = valid;
            2'd2:    trig_hit = valid & ext_trig;
            default: trig_hit = sync_edge;
        endcase
    end

    always_ff @(posedge adc0_clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        arm_take  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    arm_take  = 1'b1;
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trig_hit) begin
                    accept    = 1'b1;
                    state_nxt = last_word ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (valid) begin
                    accept = 1'b1;
                    if (last_word) state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy          = (state == S_ARMED) || (state == S_CAPTURE);
    assign done          = (state == S_DONE);
    assign words_written = cnt;

    // Single output register stage: accepted sample is presented the following cycle.
    always_ff @(posedge adc0_clk) begin
        if (!reset_n) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
            sync_prev <= 1'b0;
            mode_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
        end else begin
            bram_we <= accept;
            if (valid) sync_prev <= sync;
            if (arm_take) begin
                mode_q <= trig_mode;
                len_q  <= len_eff;
                cnt    <= '0;
            end
            if (accept) begin
                bram_addr <= wr_req.addr;
                bram_data <= wr_req.data;
                cnt       <= cnt + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_quadc_snap_capture.sv
// Directed bench for quadc_snap_capture at ADDR_W=4 (16-word depth).
module tb_quadc_snap_capture;

    localparam int AW = 4;

    logic          adc0_clk = 1'b0;
    logic          reset_n;
    logic [7:0]    adc0_data, adc1_data, adc2_data, adc3_data;
    logic          valid, sync, ext_trig, arm;
    logic [1:0]    trig_mode;
    logic [AW:0]   capture_len;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_data;
    logic          bram_we, busy, done;
    logic [AW:0]   words_written;

    int checks   = 0;
    int failures = 0;

    always #5 adc0_clk = ~adc0_clk;

    quadc_snap_capture #(.ADDR_W(AW)) dut (
        .adc0_clk(adc0_clk), .reset_n(reset_n),
        .adc0_data(adc0_data), .adc1_data(adc1_data),
        .adc2_data(adc2_data), .adc3_data(adc3_data),
        .valid(valid), .sync(sync), .ext_trig(ext_trig), .arm(arm),
        .trig_mode(trig_mode), .capture_len(capture_len),
        .bram_addr(bram_addr), .bram_data(bram_data), .bram_we(bram_we),
        .busy(busy), .done(done), .words_written(words_written)
    );

    task automatic tick;
        @(posedge adc0_clk);
        #1;
    endtask

    task automatic set_adc(input logic [7:0] a, b, c, d);
        adc0_data = a; adc1_data = b; adc2_data = c; adc3_data = d;
    endtask

    task automatic test_reset;
        reset_n = 0; arm = 0; valid = 1; sync = 1; ext_trig = 1;
        trig_mode = 0; capture_len = 5'd4;
        set_adc(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) tick;
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bram_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (bram_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", bram_addr); end
        checks++; if (bram_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", bram_data); end
        checks++; if (words_written !== 5'd0) begin failures++; $display("FAIL reset_ww got=%0d want=0", words_written); end
        reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            valid = i[0]; sync = i[1]; ext_trig = 1;
            tick;
            checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL idle_we cyc=%0d got=%b want=0", i, bram_we); end
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_busy_done cyc=%0d got=%b%b want=00", i, busy, done); end
        end
        checks++; if (words_written !== 5'd0) begin failures++; $display("FAIL idle_ww got=%0d want=0", words_written); end
        ext_trig = 0; sync = 0;
    endtask

    task automatic test_immediate;
        logic [31:0] exp_tab [4];
        exp_tab = '{32'h10203040, 32'h11213141, 32'h12223242, 32'h13233343};
        trig_mode = 0; capture_len = 5'd4; valid = 0; arm = 1;
        tick;
        arm = 0;
        checks++; if (busy !== 1'b1 || bram_we !== 1'b0) begin failures++; $display("FAIL imm_armed busy/we got=%b%b want=10", busy, bram_we); end
        for (int k = 0; k < 6; k++) begin
            valid = 1;
            set_adc(8'(32'h10 + k), 8'(32'h20 + k), 8'(32'h30 + k), 8'(32'h40 + k));
            tick;
            if (k < 4) begin
                checks++; if (bram_we !== 1'b1) begin failures++; $display("FAIL imm_we k=%0d got=%b want=1", k, bram_we); end
                checks++; if (bram_addr !== 4'(k)) begin failures++; $display("FAIL imm_addr k=%0d got=%0d want=%0d", k, bram_addr, k); end
                checks++; if (bram_data !== exp_tab[k]) begin failures++; $display("FAIL imm_data k=%0d got=%h want=%h", k, bram_data, exp_tab[k]); end
                checks++; if (words_written !== 5'(k + 1)) begin failures++; $display("FAIL imm_ww k=%0d got=%0d want=%0d", k, words_written, k + 1); end
                checks++; if (done !== (k == 3) || busy !== (k < 3)) begin failures++; $display("FAIL imm_done_busy k=%0d got=%b%b", k, done, busy); end
            end else begin
                checks++; if (bram_we !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL imm_after k=%0d we/done got=%b%b want=01", k, bram_we, done); end
                checks++; if (words_written !== 5'd4) begin failures++; $display("FAIL imm_ww_hold got=%0d want=4", words_written); end
            end
        end
    endtask

    task automatic test_sync_gaps;
        int k;
        logic v;
        logic [31:0] exp_d;
        logic [3:0]  exp_a;
        trig_mode = 1; capture_len = 5'd3;
        valid = 1; sync = 1;
        repeat (2) tick;
        arm = 1;
        tick;
        arm = 0;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            v = (c % 3 != 2);
            valid = v;
            sync  = (k < 2 || k >= 5);
            set_adc(8'(k), 8'(32'hA0 + k), 8'(32'hB0 + k), 8'(32'hC0 + k));
            tick;
            checks++; if (bram_we !== (c == 7 || c == 9 || c == 10)) begin failures++; $display("FAIL sync_we cyc=%0d got=%b", c, bram_we); end
            if (c == 7 || c == 9 || c == 10) begin
                exp_a = (c == 7) ? 4'd0 : (c == 9) ? 4'd1 : 4'd2;
                exp_d = (c == 7) ? 32'h05A5B5C5 : (c == 9) ? 32'h06A6B6C6 : 32'h07A7B7C7;
                checks++; if (bram_addr !== exp_a) begin failures++; $display("FAIL sync_addr cyc=%0d got=%0d want=%0d", c, bram_addr, exp_a); end
                checks++; if (bram_data !== exp_d) begin failures++; $display("FAIL sync_data cyc=%0d got=%h want=%h", c, bram_data, exp_d); end
            end
            checks++; if (done !== (c >= 10)) begin failures++; $display("FAIL sync_done cyc=%0d got=%b want=%b", c, done, c >= 10); end
            if (v) k++;
        end
        checks++; if (words_written !== 5'd3) begin failures++; $display("FAIL sync_ww got=%0d want=3", words_written); end
        sync = 0;
    endtask

    task automatic test_full_depth;
        logic [AW:0] lens [2];
        lens = '{5'd0, 5'd17};
        for (int r = 0; r < 2; r++) begin
            trig_mode = 0; capture_len = lens[r]; valid = 0; arm = 1;
            tick;
            arm = 0;
            for (int i = 0; i < 20; i++) begin
                valid = 1;
                set_adc(8'(i), 8'hF0, 8'hF0, 8'hF0);
                tick;
                checks++; if (bram_we !== (i < 16)) begin failures++; $display("FAIL full_we len=%0d i=%0d got=%b", lens[r], i, bram_we); end
                if (i < 16) begin
                    checks++; if (bram_addr !== 4'(i)) begin failures++; $display("FAIL full_addr len=%0d i=%0d got=%0d", lens[r], i, bram_addr); end
                    checks++; if (bram_data !== {8'(i), 24'hF0F0F0}) begin failures++; $display("FAIL full_data len=%0d i=%0d got=%h", lens[r], i, bram_data); end
                end
            end
            checks++; if (words_written !== 5'd16) begin failures++; $display("FAIL full_ww len=%0d got=%0d want=16", lens[r], words_written); end
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done len=%0d got=%b want=1", lens[r], done); end
        end
    endtask

    task automatic test_ext_rearm;
        trig_mode = 2; capture_len = 5'd2; valid = 0; ext_trig = 0; arm = 1;
        tick;
        arm = 0;
        valid = 0; ext_trig = 1;
        tick;
        checks++; if (bram_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ext_invalid_pulse we/busy got=%b%b want=01", bram_we, busy); end
        valid = 1; ext_trig = 0;
        tick;
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL ext_no_trig got=%b want=0", bram_we); end
        valid = 1; ext_trig = 1; set_adc(8'h81, 8'h82, 8'h83, 8'h84);
        tick;
        checks++; if (bram_we !== 1'b1 || bram_addr !== 4'd0) begin failures++; $display("FAIL ext_trig we/addr got=%b/%0d want=1/0", bram_we, bram_addr); end
        checks++; if (bram_data !== 32'h81828384) begin failures++; $display("FAIL ext_trig_data got=%h want=81828384", bram_data); end
        arm = 1; valid = 0; ext_trig = 0;
        tick;
        arm = 0;
        checks++; if (bram_we !== 1'b0 || busy !== 1'b1 || words_written !== 5'd1) begin failures++; $display("FAIL ext_arm_mid we/busy/ww got=%b/%b/%0d want=0/1/1", bram_we, busy, words_written); end
        valid = 1; set_adc(8'h7F, 8'h00, 8'hFF, 8'h01);
        tick;
        checks++; if (bram_we !== 1'b1 || bram_addr !== 4'd1 || bram_data !== 32'h7F00FF01) begin failures++; $display("FAIL ext_word1 we/addr/data got=%b/%0d/%h want=1/1/7f00ff01", bram_we, bram_addr, bram_data); end
        checks++; if (done !== 1'b1 || words_written !== 5'd2) begin failures++; $display("FAIL ext_done done/ww got=%b/%0d want=1/2", done, words_written); end
        arm = 1; valid = 0;
        tick;
        arm = 0;
        checks++; if (done !== 1'b0 || busy !== 1'b1 || words_written !== 5'd0) begin failures++; $display("FAIL ext_rearm done/busy/ww got=%b/%b/%0d want=0/1/0", done, busy, words_written); end
        valid = 1; ext_trig = 1; set_adc(8'h55, 8'hAA, 8'h55, 8'hAA);
        tick;
        ext_trig = 0;
        checks++; if (bram_we !== 1'b1 || bram_addr !== 4'd0 || bram_data !== 32'h55AA55AA) begin failures++; $display("FAIL ext_restart we/addr/data got=%b/%0d/%h want=1/0/55aa55aa", bram_we, bram_addr, bram_data); end
        tick;
        checks++; if (bram_addr !== 4'd1 || done !== 1'b1) begin failures++; $display("FAIL ext_restart_end addr/done got=%0d/%b want=1/1", bram_addr, done); end
    endtask

    task automatic test_reset_mid;
        trig_mode = 0; capture_len = 5'd8; valid = 0; arm = 1;
        tick;
        arm = 0;
        valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_adc(8'(i), 8'h00, 8'h00, 8'h00);
            tick;
        end
        checks++; if (words_written !== 5'd3 || bram_addr !== 4'd2) begin failures++; $display("FAIL mid_pre ww/addr got=%0d/%0d want=3/2", words_written, bram_addr); end
        reset_n = 0;
        tick;
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%b want=0", bram_we); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_rst busy/done got=%b%b want=00", busy, done); end
        checks++; if (words_written !== 5'd0) begin failures++; $display("FAIL mid_rst_ww got=%0d want=0", words_written); end
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_post i=%0d we/busy/done got=%b%b%b want=000", i, bram_we, busy, done); end
        end
    endtask

    initial begin
        test_reset;
        test_immediate;
        test_sync_gaps;
        test_full_depth;
        test_ext_rearm;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
